// File: rtl/fp16pow.sv
// fp16pow: multi-cycle FP16 integer power, o_res = i_base ^ i_exp (i_exp 0..31).
// It uses right-to-left binary exponentiation. One combinational fp16mul is
// shared between the accumulate step (acc*b) and the square step (b*b).
// Ports:
//   i_clk, i_rst    clock, asynchronous active-high reset
//   i_start         start request, sampled only in IDLE
//   i_base, i_exp   operands, captured when a start is accepted
//   o_busy          high whenever the unit is not IDLE
//   o_done          one-cycle pulse; o_res is valid in that cycle
//   o_res           result, held until the next completion

// fp16mul: combinational FP16 multiply.
// Subnormal inputs are treated as zero and subnormal results are flushed to
// zero. Rounding is round-to-nearest-even, and overflow gives +/-inf.
// Any NaN, including inf*0, is returned as {sign, 5'h1F, 10'h077}.
//   a, b   operands
//   p      product
module fp16mul (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] p
);
    logic        s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [21:0] prod;
    logic [9:0]  mant;
    logic        grd, sticky, rbit;
    logic [10:0] rnd;
    logic [7:0]  esum, eadj;

    always_comb begin
        s      = a[15] ^ b[15];
        a_zero = (a[14:10] == 5'd0);
        b_zero = (b[14:10] == 5'd0);
        a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
        a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);

        prod = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
        // The product of two 1.x significands lies in [1,4).
        // Bit 21 set means the product is in [2,4) and must be normalised.
        if (prod[21]) begin
            mant   = prod[20:11];
            grd    = prod[10];
            sticky = |prod[9:0];
        end else begin
            mant   = prod[19:10];
            grd    = prod[9];
            sticky = |prod[8:0];
        end
        rbit = grd & (sticky | mant[0]);
        rnd  = {1'b0, mant} + {10'd0, rbit};
        // When rounding carries out, the mantissa wraps to 0 and the exponent
        // goes up by one. The biased result exponent is esum - 15.
        esum = {3'd0, a[14:10]} + {3'd0, b[14:10]} + {7'd0, prod[21]} + {7'd0, rnd[10]};
        eadj = esum - 8'd15;

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            p = {s, 5'h1F, 10'h077};
        else if (a_inf || b_inf)
            p = {s, 5'h1F, 10'd0};
        else if (a_zero || b_zero)
            p = {s, 15'd0};
        else if (esum >= 8'd46)
            p = {s, 5'h1F, 10'd0};
        else if (esum <= 8'd15)
            p = {s, 15'd0};
        else
            p = {s, eadj[4:0], rnd[9:0]};
    end
endmodule

module fp16pow (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_base,
    input  logic [4:0]  i_exp,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_res
);
    typedef enum logic [1:0] {IDLE, ACC, SQR, DONE} state_t;

    state_t      state, state_n;
    logic [15:0] acc, acc_n, b, b_n, res_n, mul_a, mul_p;
    logic [4:0]  e, e_n;
    logic        done_n;

    assign mul_a = (state == ACC) ? acc : b;

    fp16mul u_mul (.a(mul_a), .b(b), .p(mul_p));

    always_comb begin
        state_n = state;
        acc_n   = acc;
        b_n     = b;
        e_n     = e;
        res_n   = o_res;
        done_n  = 1'b0;
        case (state)
            IDLE: if (i_start) begin
                acc_n   = 16'h3C00;
                b_n     = i_base;
                e_n     = i_exp;
                state_n = (i_exp == 5'd0) ? DONE : ACC;
            end
            ACC: begin
                if (e[0]) acc_n = mul_p;
                state_n = (e[4:1] == 4'd0) ? DONE : SQR;
            end
            SQR: begin
                b_n     = mul_p;
                e_n     = e >> 1;
                state_n = ACC;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // o_res and o_done are registered on the edge that enters DONE.
        // They take the accumulator value that is written on that same edge.
        if (state_n == DONE) begin
            done_n = 1'b1;
            res_n  = acc_n;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            acc    <= 16'd0;
            b      <= 16'd0;
            e      <= 5'd0;
            o_done <= 1'b0;
            o_res  <= 16'd0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            b      <= b_n;
            e      <= e_n;
            o_done <= done_n;
            o_res  <= res_n;
        end
    end

    assign o_busy = (state != IDLE);
endmodule

// File: tb/tb_fp16pow.sv
// Bench for fp16pow. A scoreboard queues the expected result and done cycle
// whenever a start is driven. A negedge monitor pops and compares them on
// each o_done.
module tb_fp16pow;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base;
    logic [4:0]  expo;
    logic        busy, done;
    logic [15:0] res;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [15:0] res_q[$];
    int          cyc_q[$];

    fp16pow dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_base(base), .i_exp(expo),
        .o_busy(busy), .o_done(done), .o_res(res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            chk("done_expected", 32'(res_q.size() != 0), 32'd1);
            if (res_q.size() != 0) begin
                chk("res", 32'(res), 32'(res_q.pop_front()));
                chk("done_cycle", 32'(cyc), 32'(cyc_q.pop_front()));
            end
        end
    end

    // The start is sampled on the edge after this negedge (cycle 0).
    // Busy is then checked in cycles 1..lat+1, and the starts at poke_a and
    // poke_b must be ignored.
    task automatic run_op(input logic [15:0] b_in, input logic [4:0] e_in,
                          input logic [15:0] exp_res, input int lat,
                          input int poke_a, input int poke_b);
        @(negedge clk);
        start = 1'b1; base = b_in; expo = e_in;
        res_q.push_back(exp_res);
        cyc_q.push_back(cyc + lat);
        for (int n = 1; n <= lat + 1; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == poke_a || n == poke_b) begin
                start = 1'b1; base = 16'h3C00; expo = 5'd1;
            end
            chk("busy", 32'(busy), 32'(n <= lat));
        end
        chk("pending", 32'(res_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base = 16'd0; expo = 5'd0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res",  32'(res),  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(16'h4000, 5'd10, 16'h6400, 8, 0, 0);
        run_op(16'hBE00, 5'd3,  16'hC2C0, 4, 0, 0);
        run_op(16'h7E00, 5'd0,  16'h3C00, 1, 0, 0);
        run_op(16'h4000, 5'd16, 16'h7C00, 10, 0, 0);
        run_op(16'h0400, 5'd2,  16'h0000, 4, 0, 0);
        run_op(16'h7C00, 5'd2,  16'h7C00, 4, 0, 0);
        run_op(16'h0001, 5'd5,  16'h0000, 6, 0, 0);
        run_op(16'hBE00, 5'd2,  16'h4080, 4, 0, 0);
        run_op(16'h7E00, 5'd1,  16'h7C77, 2, 0, 0);
        run_op(16'h4000, 5'd1,  16'h4000, 2, 0, 0);
        run_op(16'h4000, 5'd31, 16'h7C00, 10, 3, 6);

        // Reset in cycle 5 of an exp=31 operation aborts it with no o_done.
        @(negedge clk);
        start = 1'b1; base = 16'h4000; expo = 5'd31;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_res",  32'(res),  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_res_hold", 32'(res), 32'd0);

        run_op(16'h4200, 5'd2, 16'h4880, 4, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
